pipe_ctrl: RTL and testbench

Parameterised in-order pipeline control unit for the course processor. It tracks per-stage valid bits and control fields for a STAGES-deep pipeline and produces the stage enables. It also interlocks on read-after-write register hazards, resolves conditional branches in the last stage with a flush of younger stages, and holds the sign/greater flags. It sits between the instruction decoder, the register file, the data memory port and the PC/stack logic.

---
 rtl/pipe_ctrl_if.sv | 39 +++
 rtl/pipe_ctrl.sv | 71 +++++++
 tb/tb_pipe_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: control bundle between the pipeline controller and decoder, register file, memory port and PC logic
//   stall_ext                 external freeze (memory wait)
//   opcode_in, rd_in, rs_a_in, rs_b_in, rd_wb_in, rs_a_used, rs_b_used, mem_wr_in,
//   br_type_in, set_sf_in, set_gf_in   control fields of the instruction in decode
//   s, g                      ALU sign / greater results of the last-stage instruction
//   vld                       per-stage valid bits
//   fetch_en, dec_re          fetch advance and register-file read enable
//   reg_we, mem_we            last-stage writes
//   pc_en, pc_src, flush      taken-branch PC load and flush of younger stages
//   hazard, stall_cnt         RAW interlock and its saturating cycle count
//   sf, gf, op_last           flag registers and last-stage opcode
interface pipe_ctrl_if #(
   parameter int STAGES = 4,
   parameter int OPW = 5,
   parameter int RAW = 4
) ();
   logic stall_ext;
   logic [OPW-1:0] opcode_in;
   logic [RAW-1:0] rd_in, rs_a_in, rs_b_in;
   logic rd_wb_in, rs_a_used, rs_b_used, mem_wr_in;
   logic [1:0] br_type_in;
   logic set_sf_in, set_gf_in, s, g;
   logic [STAGES-1:0] vld;
   logic fetch_en, dec_re, reg_we, mem_we, pc_en, pc_src, flush, hazard, sf, gf;
   logic [OPW-1:0] op_last;
   logic [15:0] stall_cnt;
   modport master (
      output stall_ext, opcode_in, rd_in, rs_a_in, rs_b_in, rd_wb_in, rs_a_used, rs_b_used,
             mem_wr_in, br_type_in, set_sf_in, set_gf_in, s, g,
      input  vld, fetch_en, dec_re, reg_we, mem_we, pc_en, pc_src, flush, hazard, sf, gf,
             op_last, stall_cnt
   );
   modport slave (
      input  stall_ext, opcode_in, rd_in, rs_a_in, rs_b_in, rd_wb_in, rs_a_used, rs_b_used,
             mem_wr_in, br_type_in, set_sf_in, set_gf_in, s, g,
      output vld, fetch_en, dec_re, reg_we, mem_we, pc_en, pc_src, flush, hazard, sf, gf,
             op_last, stall_cnt
   );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: in-order pipeline control with RAW interlock, last-stage branch resolve/flush and sf/gf flags
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   p    pipe_ctrl_if.slave: decode-stage fields in, stage valids, enables, flags and status out
module pipe_ctrl #(
   parameter int STAGES = 4,
   parameter int OPW = 5,
   parameter int RAW = 4
) (
   input logic clk,
   input logic rst,
   pipe_ctrl_if.slave p
);
   localparam int LAST = STAGES - 1;
   typedef struct packed {
      logic [OPW-1:0] op;
      logic [RAW-1:0] rd;
      logic wb, mw;
      logic [1:0] br;
      logic ss, sg;
   } fld_t;
   logic [STAGES-1:0] vld, vld_adv, vld_hz;
   fld_t f [2:LAST];
   fld_t f_in;
   logic sf, gf, raw, taken, hz, adv, wr;
   logic [15:0] cnt;
   assign f_in = {p.opcode_in, p.rd_in, p.rd_wb_in, p.mem_wr_in, p.br_type_in, p.set_sf_in, p.set_gf_in};
   // no write-through in the register file, so the last stage still counts as a pending writer
   always_comb begin
      raw = 1'b0;
      for (int k = 2; k <= LAST; k++)
         raw = raw | (vld[k] & f[k].wb & ((p.rs_a_used & (p.rs_a_in == f[k].rd)) |
                                          (p.rs_b_used & (p.rs_b_in == f[k].rd))));
   end
   assign taken = !rst & !p.stall_ext & vld[LAST] &
                  ((f[LAST].br == 2'd1) | ((f[LAST].br == 2'd2) & sf) | ((f[LAST].br == 2'd3) & gf));
   assign hz = !rst & !p.stall_ext & !taken & vld[1] & raw;
   assign adv = !rst & !p.stall_ext & !taken & !hz;
   assign wr = !rst & !p.stall_ext & vld[LAST];
   assign vld_adv = {vld[LAST-1:0], 1'b1};
   // interlock: stages 0-1 hold, bubble into stage 2, older stages keep draining
   assign vld_hz = (vld_adv & ~STAGES'(7)) | STAGES'(vld[1:0]);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         vld <= STAGES'(1);
         for (int k = 2; k <= LAST; k++) f[k] <= '0;
         sf <= 1'b0;
         gf <= 1'b0;
         cnt <= '0;
      end else if (!p.stall_ext) begin
         vld <= taken ? STAGES'(1) : hz ? vld_hz : vld_adv;
         f[2] <= f_in;
         for (int k = 3; k <= LAST; k++) f[k] <= f[k-1];
         if (vld[LAST] & f[LAST].ss) sf <= p.s;
         if (vld[LAST] & f[LAST].sg) gf <= p.g;
         if (hz && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
      end
   assign p.vld = vld;
   assign p.fetch_en = adv & vld[0];
   assign p.dec_re = adv & vld[1];
   assign p.reg_we = wr & f[LAST].wb;
   assign p.mem_we = wr & f[LAST].mw;
   assign p.pc_en = taken;
   assign p.pc_src = taken;
   assign p.flush = taken;
   assign p.hazard = hz;
   assign p.sf = sf;
   assign p.gf = gf;
   assign p.op_last = vld[LAST] ? f[LAST].op : '1;
   assign p.stall_cnt = cnt;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: self-checking bench for pipe_ctrl at STAGES=4 (vectors, model) and STAGES=6 (fill, stall, saturation)
module tb_pipe_ctrl;
   typedef struct packed {
      logic [4:0] op;
      logic [3:0] rd, ra, rb;
      logic wb, ua, ub, mw;
      logic [1:0] br;
      logic ss, sg;
   } ins_t;
   typedef struct {
      int ins;
      logic s;
      logic [3:0] vld;
      logic [7:0] en;
      logic sf;
      logic [4:0] opl;
      int cnt;
   } vec_t;
   logic clk = 1'b0, rst4 = 1'b1, rst6 = 1'b1, st4 = 1'b0, s4 = 1'b0, g4 = 1'b0;
   ins_t d4 = '0, d6 = '0;
   int n_chk = 0, n_fail = 0;
   always #5 clk = ~clk;
   pipe_ctrl_if #(.STAGES(4)) b4 ();
   pipe_ctrl_if #(.STAGES(6)) b6 ();
   assign {b4.opcode_in, b4.rd_in, b4.rs_a_in, b4.rs_b_in, b4.rd_wb_in, b4.rs_a_used, b4.rs_b_used,
           b4.mem_wr_in, b4.br_type_in, b4.set_sf_in, b4.set_gf_in} = d4;
   assign b4.stall_ext = st4;
   assign b4.s = s4;
   assign b4.g = g4;
   assign {b6.opcode_in, b6.rd_in, b6.rs_a_in, b6.rs_b_in, b6.rd_wb_in, b6.rs_a_used, b6.rs_b_used,
           b6.mem_wr_in, b6.br_type_in, b6.set_sf_in, b6.set_gf_in} = d6;
   assign b6.stall_ext = 1'b0;
   assign b6.s = 1'b0;
   assign b6.g = 1'b0;
   pipe_ctrl #(.STAGES(4)) u4 (.clk(clk), .rst(rst4), .p(b4.slave));
   pipe_ctrl #(.STAGES(6)) u6 (.clk(clk), .rst(rst6), .p(b6.slave));
   wire [7:0] en4 = {b4.fetch_en, b4.dec_re, b4.reg_we, b4.mem_we, b4.pc_en, b4.pc_src, b4.flush, b4.hazard};
   wire [6:0] fl4 = {b4.sf, b4.gf, b4.op_last};
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask
   function automatic ins_t mk(int op, int rd, int ra, int rb, int wb, int ua, int ub, int mw, int br, int ss);
      ins_t r;
      r.op = 5'(op); r.rd = 4'(rd); r.ra = 4'(ra); r.rb = 4'(rb);
      r.wb = 1'(wb); r.ua = 1'(ua); r.ub = 1'(ub); r.mw = 1'(mw);
      r.br = 2'(br); r.ss = 1'(ss); r.sg = 1'b0;
      return r;
   endfunction
   function automatic ins_t rnd();
      ins_t r;
      int x;
      r.op = 5'($urandom);
      r.rd = 4'($urandom_range(3));
      r.ra = 4'($urandom_range(3));
      r.rb = 4'($urandom_range(3));
      r.wb = 1'($urandom_range(1));
      r.ua = 1'($urandom_range(1));
      r.ub = 1'($urandom_range(1));
      r.mw = ($urandom_range(3) == 0);
      x = int'($urandom_range(15));
      r.br = (x < 12) ? 2'd0 : 2'(x - 12);
      r.ss = ($urandom_range(3) == 0);
      r.sg = ($urandom_range(3) == 0);
      return r;
   endfunction
   task automatic vectors4();
      ins_t it [10];
      vec_t tv [14];
      it[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      it[1] = mk(1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
      it[2] = mk(2, 2, 0, 0, 1, 0, 0, 0, 0, 0);
      it[3] = mk(3, 5, 0, 0, 1, 0, 0, 0, 0, 0);
      it[4] = mk(4, 3, 0, 0, 1, 0, 0, 0, 0, 0);
      it[5] = mk(5, 4, 3, 0, 1, 1, 0, 0, 0, 0);
      it[6] = mk(6, 0, 0, 0, 0, 0, 0, 1, 0, 1);
      it[7] = mk(7, 0, 0, 0, 0, 0, 0, 0, 2, 0);
      it[8] = mk(8, 6, 0, 0, 1, 0, 0, 0, 0, 0);
      it[9] = mk(9, 7, 0, 6, 1, 0, 1, 0, 0, 0);
      tv[0]  = '{0, 1'b0, 4'b0001, 8'h80, 1'b0, 5'h1F, 0};
      tv[1]  = '{1, 1'b0, 4'b0011, 8'hC0, 1'b0, 5'h1F, 0};
      tv[2]  = '{2, 1'b0, 4'b0111, 8'hC0, 1'b0, 5'h1F, 0};
      tv[3]  = '{3, 1'b0, 4'b1111, 8'hE0, 1'b0, 5'h01, 0};
      tv[4]  = '{4, 1'b0, 4'b1111, 8'hE0, 1'b0, 5'h02, 0};
      tv[5]  = '{5, 1'b0, 4'b1111, 8'h21, 1'b0, 5'h03, 0};
      tv[6]  = '{5, 1'b0, 4'b1011, 8'h21, 1'b0, 5'h04, 1};
      tv[7]  = '{5, 1'b0, 4'b0011, 8'hC0, 1'b0, 5'h1F, 2};
      tv[8]  = '{6, 1'b0, 4'b0111, 8'hC0, 1'b0, 5'h1F, 2};
      tv[9]  = '{7, 1'b0, 4'b1111, 8'hE0, 1'b0, 5'h05, 2};
      tv[10] = '{8, 1'b1, 4'b1111, 8'hD0, 1'b0, 5'h06, 2};
      tv[11] = '{9, 1'b0, 4'b1111, 8'h0E, 1'b1, 5'h07, 2};
      tv[12] = '{0, 1'b0, 4'b0001, 8'h80, 1'b1, 5'h1F, 2};
      tv[13] = '{0, 1'b0, 4'b0011, 8'hC0, 1'b1, 5'h1F, 2};
      rst4 = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_vld", b4.vld, 1);
      chk("rst_en", en4, 0);
      chk("rst_flags", fl4, 7'h1F);
      chk("rst_cnt", b4.stall_cnt, 0);
      @(negedge clk);
      rst4 = 1'b0;
      for (int i = 0; i < 14; i++) begin
         d4 = it[tv[i].ins];
         s4 = tv[i].s;
         #1;
         chk($sformatf("tbl%0d_vld", i), b4.vld, tv[i].vld);
         chk($sformatf("tbl%0d_en", i), en4, tv[i].en);
         chk($sformatf("tbl%0d_flags", i), fl4, {tv[i].sf, 1'b0, tv[i].opl});
         chk($sformatf("tbl%0d_cnt", i), b4.stall_cnt, tv[i].cnt);
         @(negedge clk);
      end
      s4 = 1'b0;
      d4 = it[0];
      st4 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_vld", b4.vld, 4'b0111);
         chk("stall_en", en4, 0);
         chk("stall_cnt", b4.stall_cnt, 2);
         @(negedge clk);
      end
      st4 = 1'b0;
      #1;
      chk("resume_vld", b4.vld, 4'b0111);
      chk("resume_en", en4, 8'hC0);
      @(negedge clk);
      #1;
      chk("resume_fill", b4.vld, 4'b1111);
   endtask
   task automatic random4();
      ins_t prog [4096];
      ins_t d, lst;
      int q[$];
      int fp, nf;
      logic msf, mgf, v1, lv, hzr, tk, hz, nm;
      logic [15:0] mcnt;
      rst4 = 1'b1;
      @(negedge clk);
      rst4 = 1'b0;
      prog[0] = rnd();
      q = {0, -1, -1, -1};
      fp = 1;
      msf = 1'b0;
      mgf = 1'b0;
      mcnt = '0;
      for (int c = 0; c < 2000; c++) begin
         st4 = ($urandom_range(7) == 0);
         s4 = 1'($urandom_range(1));
         g4 = 1'($urandom_range(1));
         v1 = (q[1] >= 0);
         d = v1 ? prog[q[1]] : rnd();
         d4 = d;
         hzr = 1'b0;
         for (int k = 2; k < 4; k++)
            if (q[k] >= 0 && prog[q[k]].wb &&
                ((d.ua && d.ra == prog[q[k]].rd) || (d.ub && d.rb == prog[q[k]].rd)))
               hzr = 1'b1;
         hzr = hzr & v1;
         lv = (q[3] >= 0);
         lst = lv ? prog[q[3]] : '0;
         tk = !st4 && lv && (lst.br == 2'd1 || (lst.br == 2'd2 && msf) || (lst.br == 2'd3 && mgf));
         hz = !st4 && !tk && hzr;
         nm = !st4 && !tk && !hzr;
         #1;
         chk("rnd_vld", b4.vld, {q[3] >= 0, q[2] >= 0, q[1] >= 0, q[0] >= 0});
         chk("rnd_en", en4, {nm && q[0] >= 0, nm && v1, !st4 && lv && lst.wb, !st4 && lv && lst.mw, tk, tk, tk, hz});
         chk("rnd_flags", fl4, {msf, mgf, lv ? lst.op : 5'h1F});
         chk("rnd_cnt", b4.stall_cnt, mcnt);
         if (!st4) begin
            if (lv && lst.ss) msf = s4;
            if (lv && lst.sg) mgf = g4;
            nf = fp;
            if (tk || !hzr) begin
               prog[nf] = rnd();
               fp = (fp + 1) % 4096;
            end
            if (tk) q = {nf, -1, -1, -1};
            else if (hzr) begin
               void'(q.pop_back());
               q.insert(2, -1);
               if (mcnt != 16'hFFFF) mcnt++;
            end else begin
               void'(q.pop_back());
               q.push_front(nf);
            end
         end
         @(negedge clk);
      end
      st4 = 1'b0;
      #3 rst4 = 1'b1;
      #1;
      chk("arst_vld", b4.vld, 1);
      chk("arst_en", en4, 0);
      chk("arst_flags", fl4, 7'h1F);
      chk("arst_cnt", b4.stall_cnt, 0);
      @(negedge clk);
      rst4 = 1'b0;
   endtask
   task automatic test6();
      int hc;
      logic we;
      rst6 = 1'b1;
      d6 = '0;
      repeat (2) @(negedge clk);
      rst6 = 1'b0;
      for (int c = 0; c < 6; c++) begin
         #1;
         chk($sformatf("s6_fill%0d", c), b6.vld, (2 << c) - 1);
         @(negedge clk);
      end
      d6 = mk(4, 3, 0, 0, 1, 0, 0, 0, 0, 0);
      #1;
      chk("s6_prod_dec", b6.dec_re, 1);
      @(negedge clk);
      d6 = mk(5, 4, 3, 0, 1, 1, 0, 0, 0, 0);
      #1;
      hc = 0;
      we = 1'b0;
      while (b6.hazard && hc < 20) begin
         hc++;
         we = b6.reg_we;
         @(negedge clk);
         #1;
      end
      chk("s6_stall_len", hc, 4);
      chk("s6_wb_then_read", {we, b6.dec_re}, 2'b11);
      chk("s6_cnt", b6.stall_cnt, 4);
      d6 = mk(6, 3, 3, 0, 1, 1, 0, 0, 0, 0);
      repeat (87600) @(negedge clk);
      #1;
      chk("s6_sat", b6.stall_cnt, 16'hFFFF);
   endtask
   initial begin
      fork
         begin
            vectors4();
            random4();
         end
         test6();
      join
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
